// File: rtl/dm_port_arbiter.sv
// Two-master round-robin arbiter for the single-port data memory.
// Each master may hold the memory for a bounded burst, and read data is returned one cycle later with a valid strobe.
module dm_port_arbiter #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 12,
  parameter int BURST_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m0_gnt,
  output logic              m1_gnt,
  output logic              m0_rvalid,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              dm_enable_mem,
  output logic              dm_enable_writeback,
  output logic              dm_enable_fetch,
  output logic [DATA_W-1:0] dm_din,
  output logic [ADDR_W-1:0] dm_in_addr,
  output logic [ADDR_W-1:0] dm_out_addr,
  input  logic [DATA_W-1:0] dm_dout
);

  localparam int CNT_W = $clog2(BURST_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_M0,
    OWN_M1
  } owner_t;

  owner_t           owner, owner_next;
  logic [CNT_W-1:0] cnt, cnt_next, cnt_sat;
  logic             last_m1, last_m1_next;
  logic             rd_m0, rd_m1, rd_m0_next, rd_m1_next;
  logic             sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner   <= OWN_NONE;
      cnt     <= '0;
      last_m1 <= 1'b1;
      rd_m0   <= 1'b0;
      rd_m1   <= 1'b0;
    end else begin
      owner   <= owner_next;
      cnt     <= cnt_next;
      last_m1 <= last_m1_next;
      rd_m0   <= rd_m0_next;
      rd_m1   <= rd_m1_next;
    end
  end

  // Grants are suppressed while reset is held so the memory sees no access during reset.
  always_comb begin
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    if (!reset) begin
      case (owner)
        OWN_M0: begin
          if (m0_req && (cnt < CNT_MAX || !m1_req)) m0_gnt = 1'b1;
          else if (m1_req)                          m1_gnt = 1'b1;
          else if (m0_req)                          m0_gnt = 1'b1;
        end
        OWN_M1: begin
          if (m1_req && (cnt < CNT_MAX || !m0_req)) m1_gnt = 1'b1;
          else if (m0_req)                          m0_gnt = 1'b1;
          else if (m1_req)                          m1_gnt = 1'b1;
        end
        default: begin
          if (m0_req && m1_req) begin
            if (last_m1) m0_gnt = 1'b1;
            else         m1_gnt = 1'b1;
          end else if (m0_req) begin
            m0_gnt = 1'b1;
          end else if (m1_req) begin
            m1_gnt = 1'b1;
          end
        end
      endcase
    end
  end

  always_comb begin
    owner_next   = OWN_NONE;
    cnt_next     = '0;
    last_m1_next = last_m1;
    cnt_sat      = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
    if (m0_gnt) begin
      owner_next   = OWN_M0;
      cnt_next     = (owner == OWN_M0) ? cnt_sat : CNT_ONE;
      last_m1_next = 1'b0;
    end else if (m1_gnt) begin
      owner_next   = OWN_M1;
      cnt_next     = (owner == OWN_M1) ? cnt_sat : CNT_ONE;
      last_m1_next = 1'b1;
    end
    rd_m0_next = m0_gnt && !m0_we;
    rd_m1_next = m1_gnt && !m1_we;
  end

  // Memory pins follow whichever master is granted; unused buses are held at zero.
  always_comb begin
    sel_we    = m1_gnt ? m1_we    : m0_we;
    sel_addr  = m1_gnt ? m1_addr  : m0_addr;
    sel_wdata = m1_gnt ? m1_wdata : m0_wdata;
    dm_enable_mem       = m0_gnt || m1_gnt;
    dm_enable_writeback = dm_enable_mem && sel_we;
    dm_enable_fetch     = dm_enable_mem && !sel_we;
    dm_din      = dm_enable_writeback ? sel_wdata : '0;
    dm_in_addr  = dm_enable_writeback ? sel_addr  : '0;
    dm_out_addr = dm_enable_fetch     ? sel_addr  : '0;
  end

  assign m0_rvalid = rd_m0;
  assign m1_rvalid = rd_m1;
  assign m0_rdata  = dm_dout;
  assign m1_rdata  = dm_dout;

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Self-checking bench for dm_port_arbiter with a behavioural data memory and a read-return scoreboard.
module tb_dm_port_arbiter;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 12;

  logic              clk, reset;
  logic              m0_req, m0_we, m1_req, m1_we;
  logic [ADDR_W-1:0] m0_addr, m1_addr;
  logic [DATA_W-1:0] m0_wdata, m1_wdata;
  logic              m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [DATA_W-1:0] m0_rdata, m1_rdata;
  logic              dm_enable_mem, dm_enable_writeback, dm_enable_fetch;
  logic [DATA_W-1:0] dm_din, dm_dout;
  logic [ADDR_W-1:0] dm_in_addr, dm_out_addr;

  typedef struct {
    logic              r0, w0;
    logic [ADDR_W-1:0] a0;
    logic [DATA_W-1:0] d0;
    logic              r1, w1;
    logic [ADDR_W-1:0] a1;
    logic [DATA_W-1:0] d1;
    logic              g0, g1;
  } vec_t;

  typedef struct {
    int                due;
    bit                m;
    logic [DATA_W-1:0] data;
  } sb_t;

  logic [DATA_W-1:0] mem     [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] exp_mem [0:(1<<ADDR_W)-1];
  sb_t  sb[$];
  vec_t tbl[$];
  int   tests = 0, failed = 0, cyc = 0;

  dm_port_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BURST_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
    .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
    .dm_enable_mem(dm_enable_mem), .dm_enable_writeback(dm_enable_writeback),
    .dm_enable_fetch(dm_enable_fetch), .dm_din(dm_din), .dm_in_addr(dm_in_addr),
    .dm_out_addr(dm_out_addr), .dm_dout(dm_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port memory stand-in with a one-cycle registered read.
  always @(posedge clk) begin
    if (dm_enable_mem && dm_enable_fetch) dm_dout <= mem[dm_out_addr];
    if (dm_enable_mem && dm_enable_writeback) mem[dm_in_addr] = dm_din;
  end

  task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s (cycle %0d): got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r0, w0, input logic [ADDR_W-1:0] a0, input logic [DATA_W-1:0] d0,
                              input logic r1, w1, input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1,
                              input logic g0, g1);
    vec_t v;
    v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.g0 = g0; v.g1 = g1;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    sb_t e;
    m0_req = v.r0; m0_we = v.w0; m0_addr = v.a0; m0_wdata = v.d0;
    m1_req = v.r1; m1_we = v.w1; m1_addr = v.a1; m1_wdata = v.d1;
    if (v.g0 && !v.w0) begin e.due = cyc + 1; e.m = 1'b0; e.data = exp_mem[v.a0]; sb.push_back(e); end
    if (v.g1 && !v.w1) begin e.due = cyc + 1; e.m = 1'b1; e.data = exp_mem[v.a1]; sb.push_back(e); end
    if (v.g0 && v.w0) exp_mem[v.a0] = v.d0;
    if (v.g1 && v.w1) exp_mem[v.a1] = v.d1;
  endtask

  task automatic checkOutput(input vec_t v);
    logic              en, we, rv0, rv1;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d, rd;
    en = v.g0 | v.g1;
    we = v.g1 ? v.w1 : v.w0;
    a  = v.g1 ? v.a1 : v.a0;
    d  = v.g1 ? v.d1 : v.d0;
    check("m0_gnt", m0_gnt, v.g0);
    check("m1_gnt", m1_gnt, v.g1);
    check("dm_enable_mem", dm_enable_mem, en);
    check("dm_enable_writeback", dm_enable_writeback, en & we);
    check("dm_enable_fetch", dm_enable_fetch, en & ~we);
    if (!en || we) check("dm_out_addr", dm_out_addr, '0);
    else           check("dm_out_addr", dm_out_addr, a);
    if (en && we) begin
      check("dm_in_addr", dm_in_addr, a);
      check("dm_din", dm_din, d);
    end else if (!en) begin
      check("dm_in_addr", dm_in_addr, '0);
      check("dm_din", dm_din, '0);
    end
    rv0 = 1'b0; rv1 = 1'b0; rd = '0;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      rv0 = !sb[0].m; rv1 = sb[0].m; rd = sb[0].data;
      void'(sb.pop_front());
    end
    check("m0_rvalid", m0_rvalid, rv0);
    check("m1_rvalid", m1_rvalid, rv1);
    if (rv0) check("m0_rdata", m0_rdata, rd);
    if (rv1) check("m1_rdata", m1_rdata, rd);
  endtask

  task automatic run_cycle(input vec_t v);
    applyStimulus(v);
    #3;
    checkOutput(v);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) run_cycle(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  task automatic do_reset();
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
    reset = 1'b1;
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    check("reset m0_rvalid", m0_rvalid, 0);
    check("reset m1_rvalid", m1_rvalid, 0);
    check("reset dm_enable_mem", dm_enable_mem, 0);
    reset = 1'b0;
    cyc = 0;
  endtask

  initial begin
    reset = 1'b1;
    for (int i = 0; i < (1 << ADDR_W); i++) begin
      mem[i] = (i * 32'h0101_0101) ^ 32'hA5A5_0000;
      exp_mem[i] = mem[i];
    end
    mem[12'h010] = 32'hDEAD_BEEF;
    exp_mem[12'h010] = 32'hDEAD_BEEF;

    // Single accesses, write-then-read forwarding, ties and owner hand-over.
    tbl.push_back(mk(1, 0, 12'h010, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 12'hFFF, 32'h1234_5678, 0, 1));
    tbl.push_back(mk(1, 0, 12'hFFF, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 12'h020, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 12'h030, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 12'h040, 32'hAABB_CCDD, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 12'h040, 0, 0, 1));
    tbl.push_back(mk(1, 0, 12'h050, 0, 1, 0, 12'h060, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 12'h070, 0, 1, 0, 12'h080, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 12'h090, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 12'h0A0, 0, 1, 0, 12'h0B0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    do_reset();
    foreach (tbl[i]) run_cycle(tbl[i]);
    idle(1);

    // Both masters requesting continuously: bursts of four alternate.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      logic g0;
      g0 = ((i / 4) % 2) == 0;
      run_cycle(mk(1, 0, ADDR_W'(12'h100 + i), 0, 1, 0, ADDR_W'(12'h200 + i), 0, g0, ~g0));
    end
    idle(2);

    // m0 alone past saturation, then m1 joins and wins at once.
    do_reset();
    for (int i = 0; i < 8; i++) run_cycle(mk(1, 0, ADDR_W'(12'h300 + i), 0, 0, 0, 0, 0, 1, 0));
    for (int i = 0; i < 4; i++) run_cycle(mk(1, 0, 12'h310, 0, 1, 0, ADDR_W'(12'h400 + i), 0, 0, 1));
    run_cycle(mk(1, 0, 12'h311, 0, 1, 0, 12'h404, 0, 1, 0));
    idle(2);

    // Reset during the read-return cycle drops the pending rvalid.
    do_reset();
    run_cycle(mk(1, 0, 12'h010, 0, 0, 0, 0, 0, 1, 0));
    reset = 1'b1;
    m1_req = 1'b1;
    sb.delete();
    #3;
    check("rst m0_rvalid", m0_rvalid, 0);
    check("rst m0_gnt", m0_gnt, 0);
    check("rst m1_gnt", m1_gnt, 0);
    check("rst dm_enable_mem", dm_enable_mem, 0);
    check("rst dm_enable_fetch", dm_enable_fetch, 0);
    check("rst dm_enable_writeback", dm_enable_writeback, 0);
    @(posedge clk);
    #1;
    check("rst hold m0_rvalid", m0_rvalid, 0);
    check("rst hold dm_enable_mem", dm_enable_mem, 0);
    reset = 1'b0;
    cyc = 0;
    idle(3);

    check("scoreboard drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
